// File: rtl/regheap_drain_if.sv
// Bundle of drain-side signals between the accumulator heap, the drain engine and the
// downstream beat consumer. Handshake: a beat moves on a rising edge where out_v && out_ready.
interface regheap_drain_if #(
  parameter int OUT_W = 128
);
  localparam int BEATS = 1024 / OUT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic              drain_req;
  logic              relu_en;
  logic              heap_data_v;
  logic [1023:0]     heap_data;
  logic              heap_usr_rst;
  logic              busy;
  logic              out_v;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              done;
  logic [1:0]        dbg_state;

  modport slave (
    input  drain_req, relu_en, heap_data_v, heap_data, out_ready,
    output heap_usr_rst, busy, out_v, out_data, out_idx, out_last, done, dbg_state
  );

  modport master (
    output drain_req, relu_en, heap_data_v, heap_data, out_ready,
    input  heap_usr_rst, busy, out_v, out_data, out_idx, out_last, done, dbg_state
  );
endinterface

// File: rtl/regheap_drain_64x16b.sv
// Drain engine for a 64x16b accumulator heap: snapshots the heap (optional per-lane ReLU)
// into a shadow register, clears the heap, then streams the shadow out as OUT_W-bit beats.
module regheap_drain_64x16b #(
  parameter int OUT_W = 128
) (
  input  logic            clk,
  input  logic            rst,
  regheap_drain_if.slave  bus
);
  localparam int BEATS = 1024 / OUT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT_V = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1023:0]    shadow_q, shadow_d;
  logic             usr_rst_q, usr_rst_d;
  logic             done_q, done_d;
  logic [1023:0]    captured;
  logic             last_beat;
  logic             sending;

  // Negative lanes (sign bit set) become zero; everything else passes untouched.
  always_comb begin
    captured = '0;
    for (int k = 0; k < 64; k++) begin
      if (bus.relu_en && bus.heap_data[16*k+15])
        captured[16*k +: 16] = 16'h0000;
      else
        captured[16*k +: 16] = bus.heap_data[16*k +: 16];
    end
  end

  assign sending   = (state_q == S_SEND);
  assign last_beat = (idx_q == IDX_W'(BEATS - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    usr_rst_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.drain_req) state_d = S_WAIT_V;
      end
      S_WAIT_V: begin
        if (bus.heap_data_v) begin
          shadow_d  = captured;
          idx_d     = '0;
          usr_rst_d = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          if (last_beat) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      usr_rst_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      usr_rst_q <= usr_rst_d;
      done_q    <= done_d;
    end
  end

  // out_data is forced to zero outside SEND so idle cycles never expose stale shadow contents.
  assign bus.out_v        = sending;
  assign bus.out_data     = sending ? shadow_q[int'(idx_q)*OUT_W +: OUT_W] : '0;
  assign bus.out_idx      = idx_q;
  assign bus.out_last     = sending && last_beat;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.heap_usr_rst = usr_rst_q;
  assign bus.done         = done_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_regheap_drain_64x16b.sv
// Directed bench for regheap_drain_64x16b (OUT_W=128): expected beats are queued at stimulus
// time and a negedge monitor pops and compares every accepted beat.
module tb_regheap_drain_64x16b;
  localparam int OUT_W = 128;
  localparam int BEATS = 1024 / OUT_W;
  localparam int EXP_W = 1 + 3 + OUT_W;

  logic clk;
  logic rst;
  regheap_drain_if #(.OUT_W(OUT_W)) bus ();

  regheap_drain_64x16b #(.OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  logic [15:0]      cur_lanes[64];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1023:0] model_vec(input logic relu);
    logic [1023:0] v;
    v = '0;
    for (int k = 0; k < 64; k++)
      v[16*k +: 16] = (relu && cur_lanes[k][15]) ? 16'h0000 : cur_lanes[k];
    return v;
  endfunction

  task automatic push_expected(input logic relu);
    logic [1023:0] v;
    v = model_vec(relu);
    for (int i = 0; i < BEATS; i++)
      exp_q.push_back({(i == BEATS - 1), 3'(i), v[i*OUT_W +: OUT_W]});
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_heap();
    for (int k = 0; k < 64; k++) bus.heap_data[16*k +: 16] = cur_lanes[k];
  endtask

  task automatic pulse_drain();
    @(posedge clk); #1 bus.drain_req = 1'b1;
    @(posedge clk); #1 bus.drain_req = 1'b0;
  endtask

  task automatic wait_done();
    logic got;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done) begin got = 1'b1; break; end
    end
    check("done_seen", 128'(got), 128'd1);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},    128'(bus.busy),         128'd0);
    check({tag, "_out_v"},   128'(bus.out_v),        128'd0);
    check({tag, "_data"},    bus.out_data,           128'd0);
    check({tag, "_idx"},     128'(bus.out_idx),      128'd0);
    check({tag, "_last"},    128'(bus.out_last),     128'd0);
    check({tag, "_done"},    128'(bus.done),         128'd0);
    check({tag, "_usr_rst"}, 128'(bus.heap_usr_rst), 128'd0);
    check({tag, "_state"},   128'(bus.dbg_state),    128'd0);
  endtask

  // ---------------- monitor ----------------
  logic             prev_v, prev_ready, prev_last_xfer;
  logic [OUT_W-1:0] prev_data;
  logic [2:0]       prev_idx;

  always @(negedge clk) begin
    logic             exp_usr;
    logic [EXP_W-1:0] e;
    if (rst) begin
      prev_v = 1'b0; prev_ready = 1'b0; prev_last_xfer = 1'b0;
    end else begin
      exp_usr = bus.out_v && !prev_v;
      if (bus.heap_usr_rst || exp_usr)
        check("heap_usr_rst", 128'(bus.heap_usr_rst), 128'(exp_usr));
      if (bus.done || prev_last_xfer)
        check("done_pulse", 128'(bus.done), 128'(prev_last_xfer));
      if (prev_v && !prev_ready && bus.out_v) begin
        check("stall_data", bus.out_data, prev_data);
        check("stall_idx", 128'(bus.out_idx), 128'(prev_idx));
      end
      if (bus.out_v && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_beat: got idx %0d, expected no beat at %0t", bus.out_idx, $time);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", bus.out_data, e[OUT_W-1:0]);
          check("beat_idx", 128'(bus.out_idx), 128'(e[OUT_W+2:OUT_W]));
          check("beat_last", 128'(bus.out_last), 128'(e[EXP_W-1]));
        end
      end
      prev_v         = bus.out_v;
      prev_ready     = bus.out_ready;
      prev_data      = bus.out_data;
      prev_idx       = bus.out_idx;
      prev_last_xfer = bus.out_v && bus.out_ready && bus.out_last;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic found;
    rst = 1'b1;
    bus.drain_req = 1'b0; bus.relu_en = 1'b0; bus.heap_data_v = 1'b0;
    bus.heap_data = '0;   bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Ramp lanes, no ReLU; heap scribbled after capture must not leak into the beats.
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'(k);
    load_heap();
    bus.heap_data_v = 1'b1;
    push_expected(1'b0);
    pulse_drain();
    @(negedge clk);
    check("wait_busy", 128'(bus.busy), 128'd1);
    check("wait_out_v", 128'(bus.out_v), 128'd0);
    @(negedge clk);
    check("first_out_v", 128'(bus.out_v), 128'd1);
    check("ramp_beat0", bus.out_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    bus.heap_data = {64{16'hDEAD}};
    wait_done();

    // Alternating 0x8001/0x7FFF with ReLU on, then off.
    for (int k = 0; k < 64; k++) cur_lanes[k] = k[0] ? 16'h7FFF : 16'h8001;
    load_heap();
    bus.relu_en = 1'b1;
    push_expected(1'b1);
    pulse_drain();
    @(negedge clk); @(negedge clk);
    check("relu_beat0", bus.out_data, 128'h7FFF_0000_7FFF_0000_7FFF_0000_7FFF_0000);
    wait_done();
    bus.relu_en = 1'b0;
    push_expected(1'b0);
    pulse_drain();
    @(negedge clk); @(negedge clk);
    check("norelu_beat0", bus.out_data, 128'h7FFF_8001_7FFF_8001_7FFF_8001_7FFF_8001);
    wait_done();

    // Back-pressure: out_ready cycles 1,0,0 while the beats stream.
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'h1000 + 16'(k * 37);
    load_heap();
    push_expected(1'b0);
    pulse_drain();
    fork
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1 bus.out_ready = ((c % 3) == 0);
        end
        bus.out_ready = 1'b1;
      end
      wait_done();
    join

    // heap_data_v withheld for 5 cycles; capture must use data present when it rises.
    bus.heap_data_v = 1'b0;
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'hAAAA;
    load_heap();
    pulse_drain();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_busy", 128'(bus.busy), 128'd1);
      check("hold_out_v", 128'(bus.out_v), 128'd0);
      check("hold_usr_rst", 128'(bus.heap_usr_rst), 128'd0);
    end
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'h4000 | 16'(k << 4);
    load_heap();
    push_expected(1'b0);
    bus.heap_data_v = 1'b1;
    wait_done();

    // Reset while beat 3 is on the bus, then a fresh readout.
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'h1234 + 16'(k);
    load_heap();
    push_expected(1'b0);
    pulse_drain();
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.out_v && bus.out_idx == 3'd3) begin found = 1'b1; break; end
    end
    check("beat3_reached", 128'(found), 128'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs("midsend_rst");
    for (int k = 0; k < 64; k++) cur_lanes[k] = k[0] ? (16'hF000 + 16'(k)) : (16'h0100 + 16'(k));
    load_heap();
    bus.relu_en = 1'b1;
    push_expected(1'b1);
    pulse_drain();
    wait_done();
    bus.relu_en = 1'b0;

    // drain_req during SEND is dropped; drain_req on the done cycle starts a second readout.
    for (int k = 0; k < 64; k++) cur_lanes[k] = 16'h0F0F ^ 16'(k * 3);
    load_heap();
    push_expected(1'b0);
    pulse_drain();
    @(posedge clk); #1 bus.drain_req = 1'b1;
    @(posedge clk); #1 bus.drain_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.out_v && bus.out_last) begin found = 1'b1; break; end
    end
    check("last_reached", 128'(found), 128'd1);
    @(posedge clk); #1 bus.drain_req = 1'b1;
    push_expected(1'b0);
    @(negedge clk);
    check("done_coincide", 128'(bus.done), 128'd1);
    @(posedge clk); #1 bus.drain_req = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    check("final_idle", 128'(bus.busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
